// File: rtl/accum_pkg.sv
// accum_pkg: op encodings and channel-select width helper for accumulator_bank
package accum_pkg;
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    function automatic int cw(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction
endpackage

// File: rtl/addsub_sat.sv
// addsub_sat: combinational N-bit add/subtract with carry, signed overflow and optional clamp
module addsub_sat #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    input  logic         sat_en,
    output logic [N-1:0] q,
    output logic         carryo,
    output logic         ovf
);
    logic [N-1:0] w_y;
    logic [N-1:0] w_r;
    assign w_y = sub ? ~y : y;
    assign {carryo, w_r} = {1'b0, x} + {1'b0, w_y} + {{N{1'b0}}, sub};
    // inverting y folds the SUB overflow rule into the ADD one
    assign ovf = (x[N-1] == w_y[N-1]) && (w_r[N-1] != x[N-1]);
    assign q = (sat_en && ovf) ? (x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : w_r;
endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: CH-channel N-bit accumulator bank sharing one add/sub datapath
module accumulator_bank
    import accum_pkg::*;
#(
    parameter int N   = 8,
    parameter int CH  = 4,
    parameter int SAT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0]           op,
    input  logic [cw(CH)-1:0]    ch,
    input  logic [N-1:0]         A,
    output logic [N-1:0]         S,
    output logic                 out_valid,
    output logic                 carry,
    output logic                 overflow,
    output logic                 err,
    output logic [CH-1:0]        ovf_sticky,
    input  logic [cw(CH)-1:0]    rd_ch,
    output logic [N-1:0]         rd_data
);
    localparam int CW = cw(CH);
    logic [N-1:0]  r_acc [CH];
    logic [N-1:0]  r_s;
    logic          r_out_valid;
    logic          r_carry;
    logic          r_overflow;
    logic          r_err;
    logic [CH-1:0] r_sticky;
    logic [N-1:0]  w_view [2**CW];
    logic          w_ch_ok;
    logic          w_we;
    logic [CH-1:0] w_wen;
    logic          w_arith;
    logic [N-1:0]  w_q;
    logic          w_carryo;
    logic          w_ovf;
    logic [N-1:0]  w_new;
    // every select code maps to a channel or to zero, so no index runs off the array
    for (genvar g = 0; g < 2**CW; g++) begin : g_view
        if (g < CH) begin : g_in
            assign w_view[g] = r_acc[g];
        end else begin : g_out
            assign w_view[g] = '0;
        end
    end
    if (2**CW == CH) begin : g_full
        assign w_ch_ok = 1'b1;
    end else begin : g_part
        assign w_ch_ok = ch < CW'(CH);
    end
    for (genvar g = 0; g < CH; g++) begin : g_wen
        assign w_wen[g] = w_we && (ch == CW'(g));
    end
    assign w_we    = in_valid && w_ch_ok;
    assign w_arith = !op[1];
    addsub_sat #(.N(N)) u_addsub (
        .x      (w_view[ch]),
        .y      (A),
        .sub    (op == OP_SUB),
        .sat_en (SAT != 0),
        .q      (w_q),
        .carryo (w_carryo),
        .ovf    (w_ovf)
    );
    assign w_new = (op == OP_LOAD) ? A : (op == OP_CLEAR) ? '0 : w_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) r_acc[i] <= '0;
            r_s         <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
            r_sticky    <= '0;
        end else begin
            r_out_valid <= w_we;
            r_err       <= in_valid && !w_ch_ok;
            if (w_we) begin
                r_s        <= w_new;
                r_carry    <= w_arith && w_carryo;
                r_overflow <= w_arith && w_ovf;
            end
            for (int i = 0; i < CH; i++) begin
                if (w_wen[i]) begin
                    r_acc[i] <= w_new;
                    if (op == OP_CLEAR) r_sticky[i] <= 1'b0;
                    else if (w_arith && w_ovf) r_sticky[i] <= 1'b1;
                end
            end
        end
    end
    assign S          = r_s;
    assign out_valid  = r_out_valid;
    assign carry      = r_carry;
    assign overflow   = r_overflow;
    assign err        = r_err;
    assign ovf_sticky = r_sticky;
    assign rd_data    = w_view[rd_ch];
endmodule

// File: doc/accumulator_bank.md
# accumulator_bank

Parametrised multi-channel accumulator: a bank of CH independent N-bit two's-complement accumulators sharing one add/subtract datapath. Each accepted command updates one selected channel, using add, subtract, load or clear, with optional saturation. It returns the registered result with carry and overflow flags. It supersedes the single-channel, add-only accumulator on the board designs. Per-channel sticky overflow flags and a combinational peek port let display logic read any channel without disturbing the pipeline.

## Interface
Parameters:
- N, 8: accumulator and operand width, N >= 2
- CH, 4: number of channels, CH >= 1
- SAT, 0: 0 = wrap on overflow; 1 = clamp to signed min/max

Ports:
- clk: input, 1 bit. Sole clock; all state updates on the posedge.
- reset: input, 1 bit. Synchronous, active-high.
- in_valid: input, 1 bit. Command strobe; one command per cycle, always accepted.
- op: input, 2 bits. 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- ch: input, CW bits. Target channel; CW = max(1, clog2(CH)).
- A: input, N bits. Operand.
- S: output, N bits. Registered new value of the target channel.
- out_valid: output, 1 bit. Registered; high for one cycle per accepted in-range command.
- carry: output, 1 bit. Registered carry-out for ADD/SUB.
- overflow: output, 1 bit. Registered signed overflow for ADD/SUB.
- err: output, 1 bit. Registered; pulses when ch >= CH with in_valid high.
- ovf_sticky: output, CH bits. Per-channel sticky overflow.
- rd_ch: input, CW bits. Peek select.
- rd_data: output, N bits. Combinational view of acc[rd_ch]; 0 if rd_ch >= CH.

## Operation
- Reset (already decided): one clock, clk; reset is synchronous and active-high. While reset is high, all acc[i], S, carry, overflow, out_valid, err and ovf_sticky are 0 at the next edge. Reset overrides in_valid.
- ADD: {c, r} = acc + A, computed at N+1 bits. carry = c. overflow = (acc[N-1] == A[N-1]) && (r[N-1] != acc[N-1]).
- SUB: r = acc + ~A + 1. carry = carry-out: 1 means no borrow, 0 means borrow. overflow = (acc[N-1] != A[N-1]) && (r[N-1] != acc[N-1]).
- LOAD: acc = A; carry = 0, overflow = 0.
- CLEAR: acc = 0; carry = 0, overflow = 0; ovf_sticky[ch] = 0.
- Saturation, SAT = 1: when overflow = 1, the stored and output value is 2^(N-1)-1 if acc is non-negative, else -2^(N-1). The overflow and carry flags still report the unclamped operation. SAT = 0 stores r as computed.
- Sticky flag: ovf_sticky[ch] is set by any ADD/SUB with overflow = 1. It is cleared only by CLEAR on that channel or by reset.
- Idle: with in_valid = 0, no channel changes. out_valid and err are 0 next cycle. S, carry and overflow hold their last values.
- Out-of-range channel: ch >= CH, reachable only when CH is not a power of two. No state change, out_valid = 0, err = 1 for one cycle.

## Timing
- Latency 1: a command sampled at edge k updates acc[ch], S, the flags and out_valid at edge k.
- Back-to-back commands to the same channel are hazard-free. Read-modify-write completes in one cycle, so the command at edge k+1 sees the result of edge k.
- rd_data is combinational from the registers. It reflects edge-k updates during cycle k+1.
- Reset asserted mid-stream discards the command in that cycle. The first command after deassertion operates on acc = 0.

## Structure
- Package accum_pkg: op encodings OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR as 2-bit localparams, plus the CW width function.
- Sub-module addsub_sat: combinational N-bit add/subtract. Inputs x, y, sub, sat_en; outputs q, carryo, ovf. Instantiated once; its output is muxed into the register bank.
- Register bank: CH x N array with per-channel write enable decoded from ch, in_valid and the range check.

## Test plan
All scenarios use N = 8 and CH = 4 unless stated.
- Reset, then ADD ch0 A=05 on two consecutive cycles: S = 05 then 0A; carry = 0, overflow = 0; out_valid high on both cycles.
- LOAD ch1 7F, then ADD ch1 01. With SAT=0: S = 80, overflow = 1, carry = 0, ovf_sticky[1] = 1. With SAT=1: S = 7F, overflow = 1.
- LOAD ch2 00, then SUB ch2 01: S = FF, carry = 0, overflow = 0. Then SUB ch2 FF: S = 00, carry = 1.
- Interleave ADD ch0 03 and ADD ch3 10 over 4 cycles: rd_data shows ch0 = 06 and ch3 = 20; ch1 and ch2 are unchanged.
- Raise reset together with in_valid=1 (ADD ch0 FF): the next cycle shows all accumulators 00, out_valid = 0, ovf_sticky = 0.
- With CH=3, send ADD ch=3 A=01: err = 1, out_valid = 0, every rd_data unchanged. Then CLEAR ch1 after an overflow: ovf_sticky[1] = 0.
